// File: rtl/jtframe_sdram_pkg.sv
// Shared SDRAM slot types: responder FSM
// state encoding and read-latency limits.
package jtframe_sdram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DST  = 2'd2,
    RDY  = 2'd3
  } rom_st_t;

  localparam int LAT_MIN = 2;
  localparam int LAT_MAX = 15;
  localparam int LAT_W   = 4;

endpackage

// File: rtl/jtframe_rom_resp_chk.sv
// Requester protocol checker: flags a pending
// request that drops or changes address before ack.
// Ports: clk, rst, req, addr, ack in; err (sticky) out.
module jtframe_rom_resp_chk #(
  parameter int SDRAMW = 22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [SDRAMW-1:0] addr,
  input  logic              ack,
  output logic              err
);

  logic              pend;
  logic [SDRAMW-1:0] addr_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend   <= 1'b0;
      addr_p <= '0;
      err    <= 1'b0;
    end else begin
      pend   <= req && !ack;
      addr_p <= addr;
      if (pend && (!req || addr != addr_p))
        err <= 1'b1;
    end
  end

endmodule

// File: rtl/jtframe_rom_resp.sv
// SDRAM read-slot responder backed by a
// synchronous memory with fixed ack-to-data latency.
// Ports: clk, rst; sdram_req/addr in, sdram_ack,
// data_dst, data_rdy, data_read out; hold in;
// mem_addr/mem_rd out, mem_din in; err out.
module jtframe_rom_resp
  import jtframe_sdram_pkg::*;
#(
  parameter int SDRAMW  = 22,
  parameter int AW      = 16,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sdram_req,
  input  logic [SDRAMW-1:0] sdram_addr,
  output logic              sdram_ack,
  output logic              data_dst,
  output logic              data_rdy,
  output logic [15:0]       data_read,
  input  logic              hold,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_rd,
  input  logic [15:0]       mem_din,
  output logic              err
);

  // out-of-range latencies are clamped
  localparam int LAT =
    (LATENCY < LAT_MIN) ? LAT_MIN :
    (LATENCY > LAT_MAX) ? LAT_MAX :
    LATENCY;

  rom_st_t          st;
  rom_st_t          st_nx;
  logic [LAT_W-1:0] cnt;
  logic [AW-1:0]    addr_q;
  logic             rd_d;
  logic [15:0]      data_q;

  assign mem_addr = addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= st_nx;
  end

  always_comb begin
    st_nx     = st;
    sdram_ack = 1'b0;
    data_dst  = 1'b0;
    data_rdy  = 1'b0;
    unique case (st)
      IDLE: begin
        if (sdram_req && !hold) begin
          sdram_ack = 1'b1;
          st_nx     = WAIT;
        end
      end
      WAIT: begin
        // counter hits 0 as DST is entered
        if (cnt == LAT_W'(1))
          st_nx = DST;
      end
      DST: begin
        data_dst = 1'b1;
        st_nx    = RDY;
      end
      RDY: begin
        data_rdy = 1'b1;
        st_nx    = IDLE;
      end
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      addr_q    <= '0;
      mem_rd    <= 1'b0;
      rd_d      <= 1'b0;
      data_q    <= '0;
      data_read <= '0;
    end else begin
      mem_rd <= sdram_ack;
      rd_d   <= mem_rd;
      if (sdram_ack) begin
        addr_q <= sdram_addr[AW-1:0];
        cnt    <= LAT_W'(LAT - 1);
      end else if (st == WAIT) begin
        cnt <= cnt - LAT_W'(1);
      end
      if (rd_d)
        data_q <= mem_din;
      // at minimum latency the word is
      // still on mem_din during DST
      if (st == DST)
        data_read <= rd_d ? mem_din : data_q;
    end
  end

  jtframe_rom_resp_chk #(
    .SDRAMW (SDRAMW)
  ) u_chk (
    .clk  (clk),
    .rst  (rst),
    .req  (sdram_req),
    .addr (sdram_addr),
    .ack  (sdram_ack),
    .err  (err)
  );

endmodule

// File: tb/tb_jtframe_rom_resp.sv
// Bench for jtframe_rom_resp: directed requests,
// queue scoreboard checked by a negedge monitor.
module tb_jtframe_rom_resp;

  logic        clk;
  logic        rst;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack;
  logic        data_dst;
  logic        data_rdy;
  logic [15:0] data_read;
  logic        hold;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_din;
  logic        err;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int t_ack;
  int t_rdy;
  int t_rel;

  logic [15:0] mem [0:65535];
  logic [15:0] exp_addr_q[$];
  logic [15:0] exp_data_q[$];
  int          ack_t_q[$];

  jtframe_rom_resp #(
    .SDRAMW  (22),
    .AW      (16),
    .LATENCY (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sdram_req  (sdram_req),
    .sdram_addr (sdram_addr),
    .sdram_ack  (sdram_ack),
    .data_dst   (data_dst),
    .data_rdy   (data_rdy),
    .data_read  (data_read),
    .hold       (hold),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_din    (mem_din),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    for (int i = 0; i < 65536; i++)
      mem[i] = 16'(i) ^ 16'h5A5A;
    mem[16'h0123] = 16'hBEEF;
  end

  always @(posedge clk)
    if (mem_rd) mem_din <= mem[mem_addr];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event not expected", nm);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (sdram_ack) ack_t_q.push_back(cyc);
      if (mem_rd) begin
        if (exp_addr_q.size() == 0)
          bad("mem_rd_spurious");
        else
          chk("mem_addr", 32'(mem_addr),
              32'(exp_addr_q.pop_front()));
      end
      if (data_dst) begin
        if (ack_t_q.size() == 0)
          bad("dst_spurious");
        else
          chk("dst_latency", cyc - ack_t_q[0], 4);
      end
      if (data_rdy) begin
        if (ack_t_q.size() == 0)
          bad("rdy_spurious");
        else
          chk("rdy_latency",
              cyc - ack_t_q.pop_front(), 5);
        if (exp_data_q.size() == 0)
          bad("rdy_no_expect");
        else
          chk("data_read", 32'(data_read),
              32'(exp_data_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit hit");
    $fatal(1);
  end

  task automatic wait_ack();
    bit got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sdram_ack) begin
        got = 1;
        t_ack = cyc;
        break;
      end
    end
    if (!got) bad("ack_timeout");
  endtask

  task automatic wait_rdy();
    bit got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (data_rdy) begin
        got = 1;
        t_rdy = cyc;
        break;
      end
    end
    if (!got) bad("rdy_timeout");
  endtask

  task automatic do_req(input logic [21:0] a,
                        input logic [15:0] em,
                        input logic [15:0] ed,
                        input int hc);
    int n;
    exp_addr_q.push_back(em);
    exp_data_q.push_back(ed);
    @(posedge clk); #1;
    sdram_addr = a;
    sdram_req  = 1'b1;
    hold       = (hc > 0);
    if (hc > 0) begin
      n = 0;
      repeat (hc) begin
        @(negedge clk);
        if (sdram_ack) n++;
      end
      chk("hold_no_ack", n, 0);
      @(posedge clk); #1;
      hold  = 1'b0;
      t_rel = cyc;
    end
    wait_ack();
    if (hc > 0) chk("hold_release_ack", t_ack, t_rel);
    @(posedge clk); #1;
    sdram_req = 1'b0;
    wait_rdy();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    ack_t_q.delete();
    @(negedge clk);
    chk("rst_data_read", 32'(data_read), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_err", 32'(err), 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int tmp;
    rst        = 1'b1;
    sdram_req  = 1'b0;
    sdram_addr = '0;
    hold       = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(sdram_ack), 0);
    chk("rst_dst", 32'(data_dst), 0);
    chk("rst_rdy", 32'(data_rdy), 0);
    chk("rst_mem_rd", 32'(mem_rd), 0);
    chk("rst_err0", 32'(err), 0);
    chk("rst_data0", 32'(data_read), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_req(22'h000123, 16'h0123, 16'hBEEF, 0);
    chk("err_after_basic", 32'(err), 0);
    do_req(22'h3F0005, 16'h0005, 16'h5A5F, 0);
    do_req(22'h000040, 16'h0040, 16'h5A1A, 10);

    do_req(22'h000010, 16'h0010, 16'h5A4A, 0);
    tmp = t_rdy;
    do_req(22'h000011, 16'h0011, 16'h5A4B, 0);
    chk("b2b_gap", t_ack - tmp, 1);
    repeat (3) @(negedge clk);
    chk("data_read_holds", 32'(data_read), 32'h5A4B);
    chk("err_clean_run", 32'(err), 0);

    exp_addr_q.push_back(16'h0021);
    exp_data_q.push_back(16'h5A7B);
    @(posedge clk); #1;
    hold       = 1'b1;
    sdram_addr = 22'h000020;
    sdram_req  = 1'b1;
    repeat (2) @(posedge clk);
    #1 sdram_addr = 22'h000021;
    repeat (2) @(negedge clk);
    chk("err_addr_change", 32'(err), 1);
    @(posedge clk); #1;
    hold = 1'b0;
    wait_ack();
    @(posedge clk); #1;
    sdram_req = 1'b0;
    wait_rdy();
    repeat (3) @(negedge clk);
    chk("err_sticky", 32'(err), 1);

    do_reset();
    @(posedge clk); #1;
    hold       = 1'b1;
    sdram_addr = 22'h000030;
    sdram_req  = 1'b1;
    @(posedge clk); #1;
    sdram_req = 1'b0;
    hold      = 1'b0;
    repeat (2) @(negedge clk);
    chk("err_req_drop", 32'(err), 1);

    do_reset();
    exp_addr_q.push_back(16'h0123);
    @(posedge clk); #1;
    sdram_addr = 22'h000123;
    sdram_req  = 1'b1;
    wait_ack();
    @(posedge clk); #1;
    sdram_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    ack_t_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (data_dst || data_rdy) n++;
    end
    chk("abort_no_pulse", n, 0);
    do_req(22'h000123, 16'h0123, 16'hBEEF, 0);
    chk("err_final", 32'(err), 0);

    repeat (4) @(negedge clk);
    chk("exp_data_left", exp_data_q.size(), 0);
    chk("exp_addr_left", exp_addr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
